// File: rtl/lpc_pkg.sv
// Shared LPC definitions used by the LAD pad buffer and the protocol decoder.
package lpc_pkg;

   localparam int unsigned LAD_WIDTH = 4;
   localparam logic [LAD_WIDTH-1:0] LAD_IDLE = 4'hF;

   // SYNC field codes returned by a peripheral during a cycle
   typedef enum logic [LAD_WIDTH-1:0] {
      SYNC_READY      = 4'h0,
      SYNC_SHORT_WAIT = 4'h5,
      SYNC_LONG_WAIT  = 4'h6,
      SYNC_READY_MORE = 4'h9,
      SYNC_ERROR      = 4'hA
   } lpc_sync_e;

   // True for the SYNC codes that ask the host to keep waiting
   function automatic logic is_sync_wait(input logic [LAD_WIDTH-1:0] lad);
      return (lad == SYNC_SHORT_WAIT) || (lad == SYNC_LONG_WAIT);
   endfunction

endpackage

// File: rtl/lpc_lad_io_if.sv
// Internal-side bus between the LPC protocol FSM and the LAD pad buffer.
interface lpc_lad_io_if #(
   parameter int unsigned WIDTH = lpc_pkg::LAD_WIDTH
) ();

   logic             eWBus;
   logic [WIDTH-1:0] WBusDi;
   logic [WIDTH-1:0] RBusDo;
   logic             DrvActive;

   modport master (
      output eWBus,
      output WBusDi,
      input  RBusDo,
      input  DrvActive
   );

   modport slave (
      input  eWBus,
      input  WBusDi,
      output RBusDo,
      output DrvActive
   );

endinterface

// File: rtl/lpc_iobit.sv
// Single-bit tri-state pad cell: drives pad when en, always returns the pad value.
module lpc_iobit (
   input  logic en,
   input  logic d,
   output logic q,
   inout  wire  pad
);

   // Release the pad whenever the cell is not enabled
   assign pad = en ? d : 1'bz;

   // Raw pad value, including read-back of our own drive
   assign q = pad;

endmodule

// File: rtl/lpc_lad_io.sv
// LAD[3:0] bidirectional buffer with optional output/input pipeline registers
// and a reset-forced tri-state so the bus is never driven during platform reset.
module lpc_lad_io
   import lpc_pkg::*;
#(
   parameter int unsigned WIDTH   = LAD_WIDTH,
   parameter bit          OUT_REG = 1'b0,
   parameter bit          IN_REG  = 1'b0
) (
   input  logic              lclk,
   input  logic              ResetN,
   lpc_lad_io_if.slave       bus,
   inout  wire  [WIDTH-1:0]  DataBusx
);

   logic             en_d;
   logic             en_q;
   logic [WIDTH-1:0] dat_d;
   logic [WIDTH-1:0] dat_q;
   logic [WIDTH-1:0] rd_d;
   logic [WIDTH-1:0] rd_q;

   logic             en_src;
   logic [WIDTH-1:0] dat_src;
   logic             en_eff;
   logic [WIDTH-1:0] pad_rd;

   // Next-state values for the optional pipeline registers
   always_comb begin
      en_d  = bus.eWBus;
      dat_d = bus.WBusDi;
      rd_d  = pad_rd;
   end

   // Pipeline registers; read register resets to the pulled-up idle level
   always_ff @(posedge lclk or negedge ResetN) begin
      if (!ResetN) begin
         en_q  <= 1'b0;
         dat_q <= '0;
         rd_q  <= '1;
      end else begin
         en_q  <= en_d;
         dat_q <= dat_d;
         rd_q  <= rd_d;
      end
   end

   // Drive source selection; ResetN gates the enable asynchronously in both modes
   always_comb begin
      en_src  = bus.eWBus;
      dat_src = bus.WBusDi;
      if (OUT_REG) begin
         en_src  = en_q;
         dat_src = dat_q;
      end
      en_eff = ResetN & en_src;
   end

   // One tri-state cell per LAD bit, all sharing a single enable
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      lpc_iobit u_bit (
         .en  (en_eff),
         .d   (dat_src[i]),
         .q   (pad_rd[i]),
         .pad (DataBusx[i])
      );
   end

   // Read-back path: same-cycle from the pads, or one lclk later
   always_comb begin
      bus.RBusDo = pad_rd;
      if (IN_REG) begin
         bus.RBusDo = rd_q;
      end
   end

   // Status: the enable actually applied to the pads
   assign bus.DrvActive = en_eff;

endmodule

// File: tb/tb_lpc_lad_io.sv
// Scoreboard bench for lpc_lad_io: one combinational and one fully registered instance.
module tb_lpc_lad_io;
   import lpc_pkg::*;

   localparam int unsigned W = LAD_WIDTH;
   localparam logic [W-1:0] PULL = 4'hF;

   typedef struct {
      bit           sel_reg;
      logic [W-1:0] bus;
      logic [W-1:0] rd;
      logic         act;
      string        name;
   } exp_t;

   logic lclk   = 1'b0;
   logic ResetN = 1'b1;

   always #15 lclk = ~lclk;

   lpc_lad_io_if #(.WIDTH(W)) if_c ();
   lpc_lad_io_if #(.WIDTH(W)) if_r ();

   wire  [W-1:0] lad_c;
   wire  [W-1:0] lad_r;
   logic         tbe_c = 1'b0;
   logic         tbe_r = 1'b0;
   logic [W-1:0] tbd_c = '0;
   logic [W-1:0] tbd_r = '0;

   assign lad_c = tbe_c ? tbd_c : {W{1'bz}};
   assign lad_r = tbe_r ? tbd_r : {W{1'bz}};

   for (genvar i = 0; i < int'(W); i++) begin : g_pull
      pullup (lad_c[i]);
      pullup (lad_r[i]);
   end

   lpc_lad_io #(.WIDTH(W), .OUT_REG(1'b0), .IN_REG(1'b0)) u_comb (
      .lclk     (lclk),
      .ResetN   (ResetN),
      .bus      (if_c),
      .DataBusx (lad_c)
   );

   lpc_lad_io #(.WIDTH(W), .OUT_REG(1'b1), .IN_REG(1'b1)) u_reg (
      .lclk     (lclk),
      .ResetN   (ResetN),
      .bus      (if_r),
      .DataBusx (lad_r)
   );

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state for the registered instance: what the flops hold
   logic         m_en   = 1'b0;
   logic [W-1:0] m_dat  = '0;
   logic [W-1:0] m_rd   = PULL;
   logic         p_rst  = 1'b0;
   logic         p_en   = 1'b0;
   logic [W-1:0] p_dat  = '0;
   logic [W-1:0] p_bus  = PULL;

   // Called just after a rising edge: apply one vector and queue the expectations
   task automatic apply(input logic rst, input logic en, input logic [W-1:0] dat,
                        input logic want_c, input logic [W-1:0] drv_c,
                        input logic want_r, input logic [W-1:0] drv_r,
                        input string name);
      exp_t e;
      logic drive;
      logic [W-1:0] pad;
      // Flops loaded at the edge just passed from the previous cycle's inputs
      if (p_rst) begin
         m_en  = p_en;
         m_dat = p_dat;
         m_rd  = p_bus;
      end
      ResetN      = rst;
      if_c.eWBus  = en;
      if_c.WBusDi = dat;
      if_r.eWBus  = en;
      if_r.WBusDi = dat;
      if (!rst) begin
         m_en  = 1'b0;
         m_dat = '0;
         m_rd  = PULL;
      end
      // Combinational instance: pads follow inputs at once
      drive = rst & en;
      tbe_c = want_c & ~drive;
      tbd_c = drv_c;
      pad   = drive ? dat : (tbe_c ? drv_c : PULL);
      e.sel_reg = 1'b0; e.bus = pad; e.rd = pad; e.act = drive; e.name = {name, "/comb"};
      exp_q.push_back(e);
      // Registered instance: pads follow the flops, read-back lags one edge
      drive = rst & m_en;
      tbe_r = want_r & ~drive;
      tbd_r = drv_r;
      pad   = drive ? m_dat : (tbe_r ? drv_r : PULL);
      e.sel_reg = 1'b1; e.bus = pad; e.rd = m_rd; e.act = drive; e.name = {name, "/reg"};
      exp_q.push_back(e);
      p_rst = rst;
      p_en  = en;
      p_dat = dat;
      p_bus = pad;
   endtask

   // Monitor: on each falling edge, pop and compare every pending expectation
   initial begin
      exp_t e;
      logic [W-1:0] a_bus;
      logic [W-1:0] a_rd;
      logic         a_act;
      forever begin
         @(negedge lclk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a_bus = e.sel_reg ? lad_r : lad_c;
            a_rd  = e.sel_reg ? if_r.RBusDo : if_c.RBusDo;
            a_act = e.sel_reg ? if_r.DrvActive : if_c.DrvActive;
            checks++;
            if (a_bus !== e.bus) begin
               failures++;
               $display("FAIL %s DataBusx got=%h exp=%h t=%0t", e.name, a_bus, e.bus, $time);
            end
            checks++;
            if (a_rd !== e.rd) begin
               failures++;
               $display("FAIL %s RBusDo got=%h exp=%h t=%0t", e.name, a_rd, e.rd, $time);
            end
            checks++;
            if (a_act !== e.act) begin
               failures++;
               $display("FAIL %s DrvActive got=%b exp=%b t=%0t", e.name, a_act, e.act, $time);
            end
         end
      end
   end

   // Stimulus: directed test-plan vectors, then randomized traffic
   initial begin
      logic         r_rst;
      logic         r_en;
      logic [W-1:0] r_dat;
      if_c.eWBus  = 1'b0;
      if_c.WBusDi = '0;
      if_r.eWBus  = 1'b0;
      if_r.WBusDi = '0;
      #1 ResetN = 1'b0;

      @(posedge lclk); #2 apply(1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 4'h0, "reset_hold");
      @(posedge lclk); #2 apply(1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 4'h0, "reset_hold2");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 4'h0, "drive_5");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, "drive_0");
      @(posedge lclk); #2 apply(1'b1, 1'b0, 4'hE, 1'b1, 4'h3, 1'b1, 4'h3, "release_rx3");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 4'h0, "drive_C");
      @(posedge lclk); #2 apply(1'b0, 1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 4'h0, "reset_mid_drive");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 4'h0, "reset_release");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 4'h0, "drive_resume");
      @(posedge lclk); #2 apply(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, "idle");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 4'h6, "pre_edge_9_rx6");
      @(posedge lclk); #2 apply(1'b1, 1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 4'h0, "post_edge_9");
      @(posedge lclk); #2 apply(1'b1, 1'b0, 4'h9, 1'b0, 4'h0, 1'b0, 4'h0, "rd_lag_9");

      for (int n = 0; n < 200; n++) begin
         r_rst = ($urandom_range(0, 9) != 0);
         r_en  = 1'($urandom_range(0, 1));
         r_dat = W'($urandom);
         @(posedge lclk);
         #2 apply(r_rst, r_en, r_dat,
                  1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 1)), W'($urandom), "random");
      end

      @(posedge lclk);
      @(negedge lclk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lpc_lad_io.md
Name: lpc_lad_io

Overview:
- Parameterized bidirectional bus buffer for the LPC LAD[3:0] pins, instantiated inside the LPC decoder between the protocol FSM and the board-level inout pins.
- Drives the pins from an internal write bus when enabled; otherwise tri-states them.
- Continuously returns the pin value on an internal read bus.
- Clock and reset exist to support optional pipeline registers and a reset-forced tri-state, so the bus is never driven during platform reset.

Parameters:
- WIDTH, 4, bus width in bits.
- OUT_REG, 0: 0 = enable/data pass straight to the pads; 1 = eWBus/WBusDi registered on lclk (one-cycle latency).
- IN_REG, 0: 0 = RBusDo combinational from pads; 1 = RBusDo registered on lclk (one-cycle latency).

Ports:
- lclk  input  1  LPC 33 MHz clock; used only when OUT_REG or IN_REG = 1.
- ResetN  input  1  reset, asynchronous, active-low.
- eWBus  input  1  write enable; 1 = drive DataBusx.
- WBusDi  input  WIDTH  data to drive onto DataBusx.
- RBusDo  output  WIDTH  value currently present on DataBusx.
- DataBusx  inout  WIDTH  pad-side bus (LAD).
- DrvActive  output  1  effective drive enable actually applied to the pads (status; may be left unconnected).

Behaviour:
- Effective enable: en_eff = ResetN & en_src.
  - OUT_REG = 0: en_src = eWBus, dat_src = WBusDi.
  - OUT_REG = 1: en_src and dat_src are flops loaded from eWBus/WBusDi on posedge lclk. Async reset clears them to 0/all-zeros.
- DataBusx = en_eff ? dat_src : all-Z, per bit. No partial drive: all bits share the single enable.
- ResetN low forces DataBusx to Z immediately (asynchronous), in both OUT_REG modes.
- DrvActive = en_eff, so it reads 0 during reset.
- RBusDo:
  - IN_REG = 0: RBusDo = DataBusx combinationally, including while this block drives (read-back of own data). Same-cycle availability is mandatory: the LPC FSM samples it in the same clock.
  - IN_REG = 1: RBusDo is a flop sampling DataBusx on posedge lclk. Async reset value is all-ones, matching the LPC idle/pull-up level.
- Undriven bus: RBusDo reflects the raw pad value. Board pull-ups give 4'hF; in simulation without pulls, Z propagates.
- Enable toggle: in combinational mode the pads follow eWBus with zero cycles of delay. No internal turnaround insertion; turnaround timing is the FSM's responsibility.
- Reset mid-drive: the pads release within the same delta. On ResetN deassertion, drive resumes only on the first lclk edge (OUT_REG = 1) or immediately from eWBus (OUT_REG = 0).
- No X generation: with eWBus = 0, WBusDi changes never reach the pads.

Decomposition:
- Shared package lpc_pkg:
  - LAD_WIDTH = 4.
  - LAD_IDLE = 4'hF.
  - LPC sync codes, for the decoder's use.
- One natural sub-module, lpc_iobit: a single-bit tri-state cell with inputs en, d, output q and inout pad. Replicated WIDTH times via generate.
- Registers live in the top level.

Test Plan:
- Reset: ResetN = 0, eWBus = 1, WBusDi = 4'hA -> DataBusx = Z, DrvActive = 0. With a bench pull-up, RBusDo = 4'hF.
- Drive (OUT_REG = 0): ResetN = 1, eWBus = 1, WBusDi = 4'h5 -> DataBusx = 4'h5 and RBusDo = 4'h5 in the same time step. Change WBusDi to 4'h0 -> both follow at once.
- Release/receive: eWBus = 0, bench drives DataBusx = 4'h3 -> RBusDo = 4'h3, DrvActive = 0, no contention (no X on the bus).
- Reset mid-drive: eWBus = 1 with 4'hC, then pulse ResetN low between clock edges -> DataBusx goes Z asynchronously and returns to 4'hC after ResetN rises.
- OUT_REG = 1 / IN_REG = 1:
  - eWBus = 1 with 4'h9 applied before edge N -> DataBusx = 4'h9 only after edge N.
  - Bench drives 4'h6 -> RBusDo = 4'h6 one edge later.
  - Reset value of RBusDo = 4'hF.
